regfile_jtag_bridge: RTL

Converts JTAG data-register traffic into register-file accesses. Sits directly upstream of `RegisterFile`: the TAP controller supplies synchronous capture/shift/update strobes and serial TDI, and this block issues single-cycle writes (`reg_write`, `w_addr`, `w_data`, `w_mask`) and port-1 reads (`r_addr1`/`r_data1`). Read data and status are returned on TDO at the next capture.

---
 rtl/regfile_jtag_pkg.sv | 26 ++
 rtl/regfile_jtag_bridge_dr_shift.sv | 27 ++
 rtl/regfile_jtag_bridge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_jtag_pkg.sv
// Shared definitions for the JTAG-to-register-file bridge.
package regfile_jtag_pkg;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_WRITE     = 2'b01,
        CMD_READ      = 2'b10,
        CMD_WRITE_INC = 2'b11
    } cmd_e;

    // Bridge FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RD_ADDR = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    // Bit positions inside the 2-bit status field returned at capture
    localparam int STAT_RD_VALID = 0;
    localparam int STAT_ERR      = 1;

    // DR layout is {cmd[1:0], addr, mask, data}
    function automatic int dr_width(input int aw, input int mw, input int dw);
        return 2 + aw + mw + dw;
    endfunction

endpackage

// File: rtl/regfile_jtag_bridge_dr_shift.sv
// JTAG data register: parallel load on capture, LSB-first shift, tdo = bit 0.
module jtag_dr_shift #(
    parameter int DR_W = 79
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            load,
    input  logic [DR_W-1:0] load_val,
    input  logic            shift,
    input  logic            tdi,
    output logic [DR_W-1:0] dr,
    output logic            tdo
);

    // Load has priority over shift; the caller already resolves strobe conflicts
    always_ff @(posedge clk) begin
        if (srst)
            dr <= '0;
        else if (load)
            dr <= load_val;
        else if (shift)
            dr <= {tdi, dr[DR_W-1:1]};
    end

    assign tdo = dr[0];

endmodule

// File: rtl/regfile_jtag_bridge.sv
// Decodes JTAG DR updates into single-cycle register-file writes and port-1 reads.
module regfile_jtag_bridge
    import regfile_jtag_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              tdi,
    input  logic              capture_en,
    input  logic              shift_en,
    input  logic              update_en,
    output logic              tdo,
    output logic              busy,
    output logic              reg_write,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic [MASK_W-1:0] w_mask,
    output logic [ADDR_W-1:0] r_addr1,
    input  logic [DATA_W-1:0] r_data1
);

    localparam int DR_W = dr_width(ADDR_W, MASK_W, DATA_W);

    logic [DR_W-1:0]   dr;
    logic [DR_W-1:0]   cap_val;
    logic [1:0]        state;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rdata_hold;
    logic              rd_valid;
    logic              err;
    logic [1:0]        status;

    logic [1:0]        cmd_bits;
    logic [ADDR_W-1:0] dr_addr;
    logic [MASK_W-1:0] dr_mask;
    logic [DATA_W-1:0] dr_data;
    cmd_e              cmd;

    logic do_shift, do_upd, conflict, accept, drop, sample, is_wr, is_rd;

    assign {cmd_bits, dr_addr, dr_mask, dr_data} = dr;
    assign cmd = cmd_e'(cmd_bits);

    // Strobe arbitration: capture beats update beats shift; any overlap is an error
    assign conflict = (capture_en & (update_en | shift_en)) | (update_en & shift_en);
    assign do_upd   = update_en & ~capture_en;
    assign do_shift = shift_en & ~capture_en & ~update_en;

    assign busy   = (state != ST_IDLE);
    assign accept = do_upd & ~busy;
    assign drop   = do_upd & busy;
    assign is_wr  = accept & ((cmd == CMD_WRITE) | (cmd == CMD_WRITE_INC));
    assign is_rd  = accept & (cmd == CMD_READ);

    // Read data is taken on the last cycle the register file needs to settle
    assign sample = ((state == ST_RD_ADDR) && (RD_LAT == 0)) ||
                    ((state == ST_RD_WAIT) && (lat_cnt == 2'(RD_LAT)));

    always_comb begin
        status                = '0;
        status[STAT_ERR]      = err;
        status[STAT_RD_VALID] = rd_valid;
    end

    assign cap_val = {status, last_addr, {MASK_W{1'b0}}, rdata_hold};

    jtag_dr_shift #(.DR_W(DR_W)) u_dr (
        .clk      (clk),
        .srst     (srst),
        .load     (capture_en),
        .load_val (cap_val),
        .shift    (do_shift),
        .tdi      (tdi),
        .dr       (dr),
        .tdo      (tdo)
    );

    // Command FSM; RD_WAIT counts 1..RD_LAT before returning to idle
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_wr)      state <= ST_WRITE;
                    else if (is_rd) state <= ST_RD_ADDR;
                end
                ST_WRITE: state <= ST_IDLE;
                ST_RD_ADDR: begin
                    if (RD_LAT == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_RD_WAIT;
                        lat_cnt <= 2'd1;
                    end
                end
                default: begin
                    if (sample) state <= ST_IDLE;
                    else        lat_cnt <= lat_cnt + 2'd1;
                end
            endcase
        end
    end

    // Register-file request outputs and last-address tracking
    always_ff @(posedge clk) begin
        if (srst) begin
            reg_write <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            w_mask    <= '0;
            r_addr1   <= '0;
            last_addr <= '0;
        end else begin
            reg_write <= is_wr;
            if (is_wr) begin
                w_addr    <= dr_addr;
                w_data    <= dr_data;
                w_mask    <= dr_mask;
                last_addr <= (cmd == CMD_WRITE_INC) ? dr_addr + ADDR_W'(1) : dr_addr;
            end
            if (is_rd) begin
                r_addr1   <= dr_addr;
                last_addr <= dr_addr;
            end
        end
    end

    // Read data and sticky status; setting wins over the clear done by capture
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_hold <= '0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (sample)          rdata_hold <= r_data1;
            if (sample)          rd_valid   <= 1'b1;
            else if (capture_en) rd_valid   <= 1'b0;
            if (conflict | drop) err        <= 1'b1;
            else if (capture_en) err        <= 1'b0;
        end
    end

endmodule
